// File: rtl/button_debounce_repeat_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding
// and elaboration-time sizing helpers.
package button_debounce_repeat_pkg;

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } state_e;

  // Number of bits needed to hold values 0 .. v-1.
  function automatic int clog2(input int v);
    int     r;
    longint x;
    r = 0;
    x = 1;
    while (x < longint'(v)) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debounce_repeat_sync_2ff.sv
// Two-stage synchronizer for the raw button pin; both stages clear on reset
// so a button held through reset is seen as a fresh press.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s_q  <= 1'b0;
    end else begin
      s1_q <= d;
      s_q  <= s1_q;
    end
  end

  assign q = s_q;

endmodule

// File: rtl/button_debounce_repeat.sv
// Push-button conditioner: synchronize, debounce with a stability counter,
// and emit a clean level plus one-cycle press/release/auto-repeat strobes.
module button_debounce_repeat
  import button_debounce_repeat_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W = clog2(STABLE_CYCLES);
  localparam int REP_W = clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam bit REP_EN = (REPEAT_DELAY != 0);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic             btn_s;
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             first_q,   first_d;
  logic             level_q,   level_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;
  logic             repeat_q,  repeat_d;
  logic             rep_hit;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  // The first repeat waits the long delay; later ones use the short period.
  always_comb begin
    rep_hit = first_q ? (rep_cnt_q == DELAY_LAST) : (rep_cnt_q == PERIOD_LAST);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_cnt_d = rep_cnt_q;
    first_d   = first_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;

    case (state_q)
      RELEASED: begin
        if (btn_s) begin
          state_d = CHECK_PRESS;
          cnt_d   = '0;
        end
      end

      CHECK_PRESS: begin
        if (!btn_s) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = PRESSED;
          press_d   = 1'b1;
          level_d   = 1'b1;
          rep_cnt_d = '0;
          first_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (!btn_s) begin
          state_d = CHECK_RELEASE;
          cnt_d   = '0;
        end else if (REP_EN) begin
          if (rep_hit) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
            first_d   = 1'b0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
      end

      // rep_cnt is left untouched here so a short release glitch does not
      // disturb the auto-repeat schedule.
      CHECK_RELEASE: begin
        if (btn_s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = RELEASED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      rep_cnt_q <= '0;
      first_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rep_cnt_q <= rep_cnt_d;
      first_q   <= first_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Directed bench for button_debounce_repeat with STABLE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3, plus a REPEAT_DELAY=0 instance.
module tb_button_debounce_repeat;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;

  logic lvl, prs, rls, rpt;
  logic lvl2, prs2, rls2, rpt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_debounce_repeat #(
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_level     (lvl),
    .press_pulse   (prs),
    .release_pulse (rls),
    .repeat_pulse  (rpt)
  );

  button_debounce_repeat #(
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (0),
    .REPEAT_PERIOD (3)
  ) u_norep (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .btn_level     (lvl2),
    .press_pulse   (prs2),
    .release_pulse (rls2),
    .repeat_pulse  (rpt2)
  );

  // Advance one rising edge; outputs are then sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Vectors below are {btn_level, press_pulse, release_pulse, repeat_pulse}.
  // In every loop, the btn_in value set before step() is the level seen at edge j.

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = 1'b1;
    repeat (3) step();
    total++;
    if ({lvl, prs, rls, rpt} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_main got=%b want=0000", {lvl, prs, rls, rpt});
    end
    total++;
    if ({lvl2, prs2, rls2, rpt2} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_norep got=%b want=0000", {lvl2, prs2, rls2, rpt2});
    end
    btn_in = 1'b0;
    rst    = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step();
      total++;
      if ({lvl, prs, rls, rpt} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_idle j=%0d got=%b want=0000", j, {lvl, prs, rls, rpt});
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] want;
    logic [3:0] want2;
    for (int j = 1; j <= 40; j++) begin
      btn_in = (j <= 30);
      step();
      want[3] = (j >= 7 && j < 37);
      want[2] = (j == 7);
      want[1] = (j == 37);
      want[0] = (j >= 17 && j <= 32 && ((j - 17) % 3) == 0);
      want2   = {want[3:1], 1'b0};
      total++;
      if ({lvl, prs, rls, rpt} !== want) begin
        bad++;
        $display("FAIL clean j=%0d got=%b want=%b", j, {lvl, prs, rls, rpt}, want);
      end
      total++;
      if ({lvl2, prs2, rls2, rpt2} !== want2) begin
        bad++;
        $display("FAIL clean_norep j=%0d got=%b want=%b", j, {lvl2, prs2, rls2, rpt2}, want2);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] want;
    for (int j = 1; j <= 35; j++) begin
      btn_in = (j <= 4) ? ((j % 2) == 1) : (j <= 24);
      step();
      want[3] = (j >= 11 && j < 31);
      want[2] = (j == 11);
      want[1] = (j == 31);
      want[0] = (j == 21 || j == 24);
      total++;
      if ({lvl, prs, rls, rpt} !== want) begin
        bad++;
        $display("FAIL bounce j=%0d got=%b want=%b", j, {lvl, prs, rls, rpt}, want);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] want;
    for (int j = 1; j <= 55; j++) begin
      btn_in = (j <= 44) && (j != 26) && (j != 27);
      step();
      want[3] = (j >= 7 && j < 51);
      want[2] = (j == 7);
      want[1] = (j == 51);
      want[0] = (j == 17 || j == 20 || j == 23 || j == 26 || j == 32 ||
                 j == 35 || j == 38 || j == 41 || j == 44);
      total++;
      if ({lvl, prs, rls, rpt} !== want) begin
        bad++;
        $display("FAIL glitch j=%0d got=%b want=%b", j, {lvl, prs, rls, rpt}, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] want;
    for (int j = 1; j <= 56; j++) begin
      rst    = (j == 5) || (j == 26);
      btn_in = (j <= 45);
      step();
      want[3] = (j >= 12 && j < 26) || (j >= 33 && j < 52);
      want[2] = (j == 12 || j == 33);
      want[1] = (j == 52);
      want[0] = (j == 22 || j == 25 || j == 43 || j == 46);
      total++;
      if ({lvl, prs, rls, rpt} !== want) begin
        bad++;
        $display("FAIL reset_mid j=%0d got=%b want=%b", j, {lvl, prs, rls, rpt}, want);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_no_repeat();
    logic [3:0] want;
    for (int j = 1; j <= 110; j++) begin
      btn_in = (j <= 100);
      step();
      want[3] = (j >= 7 && j < 107);
      want[2] = (j == 7);
      want[1] = (j == 107);
      want[0] = 1'b0;
      total++;
      if ({lvl2, prs2, rls2, rpt2} !== want) begin
        bad++;
        $display("FAIL no_repeat j=%0d got=%b want=%b", j, {lvl2, prs2, rls2, rpt2}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_no_repeat();
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
